// File: rtl/pipe_pkg.sv
// Shared constants and beat type for the elastic pipeline register chain.
package pipe_pkg;

    localparam int unsigned PIPE_DEF_WIDTH = 32;
    localparam int unsigned PIPE_DEF_DEPTH = 2;
    localparam int unsigned STALL_CNT_W    = 16;

    // Valid-tagged payload for users with a fixed default width
    typedef struct packed {
        logic                      valid;
        logic [PIPE_DEF_WIDTH-1:0] data;
    } pipe_beat_t;

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid bit plus payload register, loads when empty or draining.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             dst_ready,
    output logic             stg_valid,
    output logic [WIDTH-1:0] stg_data
);

    logic             w_rdy;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign w_rdy = !r_valid || dst_ready;

    // Payload only loads on a valid source so stale data is never overwritten by bubbles
    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_rdy) begin
            r_valid <= src_valid;
            if (src_valid) begin
                r_data <= src_data;
            end
        end
    end

    assign stg_valid = r_valid;
    assign stg_data  = r_data;

endmodule

// File: rtl/pipe_reg_sync.sv
// DEPTH-stage valid/ready register chain with sync clear and flush.
// Optional PIPE_REG_STALL_CNT_EN adds a saturating output-stall counter.
module pipe_reg_sync
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEF_WIDTH,
    parameter int unsigned DEPTH = PIPE_DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_sync: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_dst_rdy;
    logic             w_acc;

    // Ready ripples combinationally from the output back to stage 0
    always_comb begin
        w_acc     = out_ready;
        w_rdy     = '0;
        w_dst_rdy = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            w_dst_rdy[k] = w_acc;
            w_rdy[k]     = !w_valid[k] || w_acc;
            w_acc        = w_rdy[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (k == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_body
            assign w_src_valid = w_valid[k-1];
            assign w_src_data  = w_data[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .clr       (clr),
            .flush     (flush),
            .src_valid (w_src_valid),
            .src_data  (w_src_data),
            .dst_ready (w_dst_rdy[k]),
            .stg_valid (w_valid[k]),
            .stg_data  (w_data[k])
        );
    end

    assign in_ready  = w_rdy[0] && !flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

`ifdef PIPE_REG_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Counts cycles the output is held by downstream; survives flush
    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_reg_sync.sv
// Directed bench for pipe_reg_sync (WIDTH=32, DEPTH=2): stream, backpressure,
// bubble collapse, flush, clear priority and, with PIPE_REG_STALL_CNT_EN, the stall counter.
module tb_pipe_reg_sync;

    logic        clk;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_REG_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_reg_sync #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clr       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream 1..8, two-cycle latency, no gaps
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_out_valid", 32'(out_valid), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) chk("stream_out_data", out_data, 32'(i - 1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        chk("stream_last_data", out_data, 32'd8);
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: two beats fill the chain, third is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        #1;
        chk("bp_rdy_a", 32'(in_ready), 32'd1);
        tick();
        in_data = 32'hB;
        #1;
        chk("bp_rdy_b", 32'(in_ready), 32'd1);
        tick();
        chk("bp_out_a", out_data, 32'hA);
        chk("bp_valid_a", 32'(out_valid), 32'd1);
        in_data = 32'hC;
        #1;
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("bp_stable_data", out_data, 32'hA);
        chk("bp_stable_valid", 32'(out_valid), 32'd1);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_full_consume_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp_out_b", out_data, 32'hB);
        in_valid = 1'b0;
        tick();
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Bubble collapse: lone beat moves to the last stage while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("bub_out_valid", 32'(out_valid), 32'd1);
        chk("bub_out_data", out_data, 32'h55);
        chk("bub_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h66;
        tick();
        in_valid = 1'b0;
        #1;
        chk("bub_now_full", 32'(in_ready), 32'd0);
        chk("bub_hold_55", out_data, 32'h55);
        out_ready = 1'b1;
        tick();
        chk("bub_out_66", out_data, 32'h66);
        tick();
        chk("bub_drained", 32'(out_valid), 32'd0);

        // Flush drops 0x11/0x22 and refuses 0x33; 0x44 exits alone
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_full_out", out_data, 32'h11);
        flush   = 1'b1;
        in_data = 32'h33;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("fl_no_33", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h44;
        tick();
        in_valid = 1'b0;
        tick();
        chk("fl_44_valid", 32'(out_valid), 32'd1);
        chk("fl_44_data", out_data, 32'h44);
        tick();
        chk("fl_44_alone", 32'(out_valid), 32'd0);

        // Clear beats flush and handshake on the same edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        tick();
        in_data = 32'h88;
        tick();
        chk("clr_full_out", out_data, 32'h77);
        clr       = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h99;
        tick();
        clr      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_out_data", out_data, 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("clr_no_99", 32'(out_valid), 32'd0);
`ifdef PIPE_REG_STALL_CNT_EN
        chk("cnt_after_clr", 32'(stall_cnt), 32'd0);

        // Stall counter: five held cycles, then saturation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_zero_at_arrival", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_five", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 70000; i++) tick();
        chk("cnt_saturated", 32'(stall_cnt), 32'hFFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("cnt_cleared", 32'(stall_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
